// File: rtl/spi_flash_responder.sv
// SPI Mode 0 serial-flash responder: READ, WREN, PAGE PROGRAM and READ STATUS
// against an internal byte array, with a timed write-in-progress window.
module spi_flash_responder #(
  parameter int ADDR_BITS         = 12,
  parameter int SYNC_STAGES       = 2,
  parameter int WRITE_BUSY_CYCLES = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic i_SPI_CLK,
  input  logic i_SPI_MOSI,
  input  logic i_SPI_CS,
  output logic o_SPI_MISO,
  output logic o_busy,
  output logic o_wel,
  output logic o_cmd_error
);

  localparam int BUSY_W = $clog2(WRITE_BUSY_CYCLES + 1);
  localparam logic [BUSY_W-1:0] BUSY_LOAD = BUSY_W'(WRITE_BUSY_CYCLES);

  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_PROG   = 8'h02;
  localparam logic [7:0] OP_WREN   = 8'h06;
  localparam logic [7:0] OP_STATUS = 8'h05;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_READ_DATA,
    ST_PROG_DATA,
    ST_STATUS,
    ST_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic                   sck_prev_q, cs_prev_q;

  state_t                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [1:0]             byte_cnt_q, byte_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             tx_q, tx_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   started_q, started_d;
  logic                   is_prog_q, is_prog_d;
  logic                   prog_any_q, prog_any_d;
  logic                   wren_pend_q, wren_pend_d;
  logic                   wel_q, wel_d;
  logic                   busy_q, busy_d;
  logic [BUSY_W-1:0]      busy_cnt_q, busy_cnt_d;
  logic                   cmd_err_q, cmd_err_d;

  logic [7:0]             mem [0:(1<<ADDR_BITS)-1];
  logic                   mem_we;

  logic sck, mosi, cs;
  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic [7:0] rx_byte;
  logic [7:0] status_byte;

  assign sck      = sck_sync_q[SYNC_STAGES-1];
  assign mosi     = mosi_sync_q[SYNC_STAGES-1];
  assign cs       = cs_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck & ~sck_prev_q;
  assign sck_fall = ~sck & sck_prev_q;
  assign cs_rise  = cs & ~cs_prev_q;
  assign cs_fall  = ~cs & cs_prev_q;
  assign rx_byte  = {shift_q[6:0], mosi};

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], i_SPI_CLK};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_SPI_MOSI};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], i_SPI_CS};
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    addr_d      = addr_q;
    started_d   = started_q;
    is_prog_d   = is_prog_q;
    prog_any_d  = prog_any_q;
    wren_pend_d = wren_pend_q;
    wel_d       = wel_q;
    busy_d      = busy_q;
    busy_cnt_d  = busy_cnt_q;
    cmd_err_d   = 1'b0;
    mem_we      = 1'b0;

    if (busy_q) begin
      busy_cnt_d = busy_cnt_q - BUSY_W'(1);
      if (busy_cnt_q == BUSY_W'(1)) begin
        busy_d = 1'b0;
      end
    end

    // Captured from busy_d so an expiry in the capture clk already reads as 0.
    status_byte = {6'b0, wel_q, busy_d};

    if (cs) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = 3'd0;
      byte_cnt_d  = 2'd0;
      started_d   = 1'b0;
      prog_any_d  = 1'b0;
      wren_pend_d = 1'b0;
      if (cs_rise) begin
        if (state_q == ST_PROG_DATA) begin
          wel_d = 1'b0;
          if (prog_any_q) begin
            busy_d     = 1'b1;
            busy_cnt_d = BUSY_LOAD;
          end
        end else if (state_q == ST_IGNORE && wren_pend_q && !busy_q) begin
          wel_d = 1'b1;
        end
      end
    end else if (cs_fall) begin
      state_d    = ST_CMD;
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 2'd0;
      started_d  = 1'b0;
    end else begin
      if (sck_rise) begin
        shift_d   = rx_byte;
        bit_cnt_d = bit_cnt_q + 3'd1;
      end

      unique case (state_q)
        ST_CMD: begin
          if (sck_rise && bit_cnt_q == 3'd7) begin
            started_d = 1'b0;
            case (rx_byte)
              OP_READ: begin
                is_prog_d = 1'b0;
                if (busy_q) begin
                  state_d   = ST_IGNORE;
                  cmd_err_d = 1'b1;
                end else begin
                  state_d = ST_ADDR;
                end
              end
              OP_PROG: begin
                is_prog_d = 1'b1;
                if (!wel_q || busy_q) begin
                  state_d   = ST_IGNORE;
                  cmd_err_d = 1'b1;
                end else begin
                  state_d = ST_ADDR;
                end
              end
              OP_WREN: begin
                state_d     = ST_IGNORE;
                wren_pend_d = 1'b1;
              end
              OP_STATUS: begin
                state_d = ST_STATUS;
                tx_d    = status_byte;
              end
              default: begin
                state_d   = ST_IGNORE;
                cmd_err_d = 1'b1;
              end
            endcase
          end
        end

        ST_ADDR: begin
          if (sck_rise) begin
            addr_d = {addr_q[ADDR_BITS-2:0], mosi};
            if (bit_cnt_q == 3'd7) begin
              if (byte_cnt_q == 2'd2) begin
                byte_cnt_d = 2'd0;
                started_d  = 1'b0;
                if (is_prog_q) begin
                  state_d = ST_PROG_DATA;
                end else begin
                  state_d = ST_READ_DATA;
                  tx_d    = mem[addr_d];
                end
              end else begin
                byte_cnt_d = byte_cnt_q + 2'd1;
              end
            end
          end
        end

        // The falling edge right after the last header bit must not shift,
        // so shifting only starts once a data-phase rising edge was seen.
        ST_READ_DATA: begin
          if (sck_rise) begin
            started_d = 1'b1;
          end else if (sck_fall && started_q) begin
            if (bit_cnt_q == 3'd0) begin
              addr_d = addr_q + ADDR_BITS'(1);
              tx_d   = mem[addr_d];
            end else begin
              tx_d = {tx_q[6:0], 1'b0};
            end
          end
        end

        ST_STATUS: begin
          if (sck_rise) begin
            started_d = 1'b1;
          end else if (sck_fall && started_q) begin
            if (bit_cnt_q == 3'd0) begin
              tx_d = status_byte;
            end else begin
              tx_d = {tx_q[6:0], 1'b0};
            end
          end
        end

        ST_PROG_DATA: begin
          if (sck_rise && bit_cnt_q == 3'd7) begin
            mem_we     = 1'b1;
            prog_any_d = 1'b1;
            addr_d     = {addr_q[ADDR_BITS-1:8], addr_q[7:0] + 8'd1};
          end
        end

        ST_IGNORE: begin
          if (sck_rise) begin
            wren_pend_d = 1'b0;
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= 2'd0;
      shift_q     <= 8'd0;
      tx_q        <= 8'd0;
      addr_q      <= '0;
      started_q   <= 1'b0;
      is_prog_q   <= 1'b0;
      prog_any_q  <= 1'b0;
      wren_pend_q <= 1'b0;
      wel_q       <= 1'b0;
      busy_q      <= 1'b0;
      busy_cnt_q  <= '0;
      cmd_err_q   <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      sck_prev_q  <= sck;
      cs_prev_q   <= cs;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      started_q   <= started_d;
      is_prog_q   <= is_prog_d;
      prog_any_q  <= prog_any_d;
      wren_pend_q <= wren_pend_d;
      wel_q       <= wel_d;
      busy_q      <= busy_d;
      busy_cnt_q  <= busy_cnt_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  // Array contents survive reset, so the write port has no reset branch.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= rx_byte;
    end
  end

  assign o_SPI_MISO  = ((state_q == ST_READ_DATA || state_q == ST_STATUS) && !cs) ? tx_q[7] : 1'bz;
  assign o_busy      = busy_q;
  assign o_wel       = wel_q;
  assign o_cmd_error = cmd_err_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: drives SPI Mode 0 transactions
// (SCK = clk/10) and compares MISO, WEL, WIP and error pulses against fixed values.
module tb_spi_flash_responder;

  logic clk;
  logic reset;
  logic i_spi_clk;
  logic i_spi_mosi;
  logic i_spi_cs;
  wire  miso;
  logic busy;
  logic wel;
  logic cmd_error;

  int checks;
  int failures;
  int err_pulses;

  logic [7:0] rd_buf [0:3];
  logic [7:0] wr_buf [0:3];
  logic [7:0] junk;

  // Weak pull-up so a released MISO reads as 1.
  pullup (miso);

  spi_flash_responder dut (
    .clk        (clk),
    .reset      (reset),
    .i_SPI_CLK  (i_spi_clk),
    .i_SPI_MOSI (i_spi_mosi),
    .i_SPI_CS   (i_spi_cs),
    .o_SPI_MISO (miso),
    .o_busy     (busy),
    .o_wel      (wel),
    .o_cmd_error(cmd_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_error === 1'b1) err_pulses++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  task automatic spi_bit(input logic b, output logic r);
    i_spi_mosi = b;
    #50;
    r = miso;
    i_spi_clk = 1'b1;
    #50;
    i_spi_clk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) spi_bit(tx[i], rx[i]);
  endtask

  task automatic spi_begin();
    i_spi_cs = 1'b0;
    #100;
  endtask

  task automatic spi_end();
    #50;
    i_spi_cs = 1'b1;
  endtask

  task automatic spi_gap();
    #200;
  endtask

  task automatic spi_header(input logic [7:0] op, input logic [23:0] a);
    spi_byte(op, junk);
    spi_byte(a[23:16], junk);
    spi_byte(a[15:8], junk);
    spi_byte(a[7:0], junk);
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    spi_begin();
    spi_header(8'h03, a);
    for (int k = 0; k < n; k++) spi_byte(8'h00, rd_buf[k]);
    spi_end();
    spi_gap();
  endtask

  task automatic do_wren();
    spi_begin();
    spi_byte(8'h06, junk);
    spi_end();
    spi_gap();
  endtask

  // Counts clk cycles with WIP set, starting right after CS rises.
  task automatic measure_busy(output int n);
    n = 0;
    for (int i = 0; i < 20 && busy !== 1'b1; i++) @(negedge clk);
    for (int i = 0; i < 1000 && busy === 1'b1; i++) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_program(input logic [23:0] a, input int n);
    int cyc;
    do_wren();
    spi_begin();
    spi_header(8'h02, a);
    for (int k = 0; k < n; k++) spi_byte(wr_buf[k], junk);
    spi_end();
    measure_busy(cyc);
    spi_gap();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #20;
    reset = 1'b0;
    #30;
    checks++; if (miso !== 1'b1) begin failures++; $display("[TB] FAIL reset_miso: got %b expected released(1)", miso); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (wel !== 1'b0) begin failures++; $display("[TB] FAIL reset_wel: got %b expected 0", wel); end
    checks++; if (cmd_error !== 1'b0) begin failures++; $display("[TB] FAIL reset_cmd_error: got %b expected 0", cmd_error); end
    reset = 1'b1;
    #50;
  endtask

  task automatic test_write_enable();
    logic r;
    spi_begin();
    spi_byte(8'h06, junk);
    spi_bit(1'b0, r);
    spi_end();
    spi_gap();
    checks++; if (wel !== 1'b0) begin failures++; $display("[TB] FAIL wren_9bits: wel got %b expected 0", wel); end
    do_wren();
    checks++; if (wel !== 1'b1) begin failures++; $display("[TB] FAIL wren: wel got %b expected 1", wel); end
  endtask

  task automatic test_program();
    int n;
    spi_begin();
    spi_header(8'h02, 24'h000123);
    spi_byte(8'hA5, junk);
    spi_end();
    measure_busy(n);
    checks++; if (n !== 100) begin failures++; $display("[TB] FAIL busy_window: got %0d clk expected 100", n); end
    checks++; if (wel !== 1'b0) begin failures++; $display("[TB] FAIL prog_wel_clear: got %b expected 0", wel); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL busy_end: got %b expected 0", busy); end
    spi_gap();
    do_read(24'h000123, 1);
    checks++; if (rd_buf[0] !== 8'hA5) begin failures++; $display("[TB] FAIL read_back: got %h expected a5", rd_buf[0]); end
    do_read(24'hABC123, 1);
    checks++; if (rd_buf[0] !== 8'hA5) begin failures++; $display("[TB] FAIL read_alias: got %h expected a5", rd_buf[0]); end
  endtask

  task automatic test_program_no_wel();
    int n;
    int e0;
    e0 = err_pulses;
    spi_begin();
    spi_header(8'h02, 24'h000123);
    spi_byte(8'h5A, junk);
    spi_end();
    measure_busy(n);
    checks++; if (n !== 0) begin failures++; $display("[TB] FAIL nowel_busy: got %0d clk expected 0", n); end
    checks++; if (err_pulses !== e0 + 1) begin failures++; $display("[TB] FAIL nowel_err: got %0d pulses expected 1", err_pulses - e0); end
    spi_gap();
    do_read(24'h000123, 1);
    checks++; if (rd_buf[0] !== 8'hA5) begin failures++; $display("[TB] FAIL nowel_unchanged: got %h expected a5", rd_buf[0]); end
  endtask

  task automatic test_bad_opcode();
    int e0;
    logic [7:0] rx;
    e0 = err_pulses;
    spi_begin();
    spi_byte(8'h9F, junk);
    spi_byte(8'h00, rx);
    spi_end();
    spi_gap();
    checks++; if (err_pulses !== e0 + 1) begin failures++; $display("[TB] FAIL bad_op_err: got %0d pulses expected 1", err_pulses - e0); end
    checks++; if (rx !== 8'hFF) begin failures++; $display("[TB] FAIL bad_op_miso: got %h expected released(ff)", rx); end
  endtask

  task automatic test_read_while_busy();
    int e0;
    logic [7:0] rx;
    do_wren();
    spi_begin();
    spi_header(8'h02, 24'h000200);
    spi_byte(8'h3C, junk);
    spi_end();
    #50;
    e0 = err_pulses;
    spi_begin();
    spi_header(8'h03, 24'h000123);
    spi_byte(8'h00, rx);
    spi_end();
    checks++; if (rx !== 8'hFF) begin failures++; $display("[TB] FAIL busy_read_miso: got %h expected released(ff)", rx); end
    checks++; if (err_pulses !== e0 + 1) begin failures++; $display("[TB] FAIL busy_read_err: got %0d pulses expected 1", err_pulses - e0); end
    for (int i = 0; i < 300 && busy === 1'b1; i++) @(negedge clk);
    spi_gap();
    do_read(24'h000200, 1);
    checks++; if (rd_buf[0] !== 8'h3C) begin failures++; $display("[TB] FAIL prog_200: got %h expected 3c", rd_buf[0]); end
  endtask

  task automatic test_status_poll();
    logic [7:0] rx;
    int polls;
    do_wren();
    spi_begin();
    spi_byte(8'h05, junk);
    spi_byte(8'h00, rx);
    spi_end();
    spi_gap();
    checks++; if (rx !== 8'h02) begin failures++; $display("[TB] FAIL status_wel: got %h expected 02", rx); end
    spi_begin();
    spi_header(8'h02, 24'h000201);
    spi_byte(8'hC3, junk);
    spi_end();
    #50;
    spi_begin();
    spi_byte(8'h05, junk);
    spi_byte(8'h00, rx);
    checks++; if (rx !== 8'h01) begin failures++; $display("[TB] FAIL status_wip: got %h expected 01", rx); end
    polls = 0;
    while (polls < 20 && rx !== 8'h00) begin
      spi_byte(8'h00, rx);
      polls++;
    end
    spi_end();
    spi_gap();
    checks++; if (rx !== 8'h00) begin failures++; $display("[TB] FAIL status_clear: got %h expected 00 after %0d polls", rx, polls); end
    checks++; if (polls !== 1) begin failures++; $display("[TB] FAIL status_poll_count: got %0d expected 1", polls); end
  endtask

  task automatic test_wrap();
    wr_buf[0] = 8'h44;
    do_program(24'h000100, 1);
    wr_buf[0] = 8'h11; wr_buf[1] = 8'h22; wr_buf[2] = 8'h33;
    do_program(24'h0000FE, 3);
    wr_buf[0] = 8'h77;
    do_program(24'h000FFF, 1);
    do_read(24'h000FFF, 2);
    checks++; if (rd_buf[0] !== 8'h77) begin failures++; $display("[TB] FAIL wrap_fff: got %h expected 77", rd_buf[0]); end
    checks++; if (rd_buf[1] !== 8'h33) begin failures++; $display("[TB] FAIL wrap_000: got %h expected 33", rd_buf[1]); end
    do_read(24'h0000FE, 2);
    checks++; if (rd_buf[0] !== 8'h11) begin failures++; $display("[TB] FAIL page_fe: got %h expected 11", rd_buf[0]); end
    checks++; if (rd_buf[1] !== 8'h22) begin failures++; $display("[TB] FAIL page_ff: got %h expected 22", rd_buf[1]); end
    do_read(24'h000100, 1);
    checks++; if (rd_buf[0] !== 8'h44) begin failures++; $display("[TB] FAIL page_no_spill: got %h expected 44", rd_buf[0]); end
  endtask

  task automatic test_partial_program();
    int n;
    logic r;
    wr_buf[0] = 8'h96;
    do_program(24'h000300, 1);
    do_wren();
    spi_begin();
    spi_header(8'h02, 24'h000300);
    spi_bit(1'b1, r); spi_bit(1'b0, r); spi_bit(1'b1, r); spi_bit(1'b0, r);
    spi_end();
    measure_busy(n);
    checks++; if (n !== 0) begin failures++; $display("[TB] FAIL partial_busy: got %0d clk expected 0", n); end
    checks++; if (wel !== 1'b0) begin failures++; $display("[TB] FAIL partial_wel: got %b expected 0", wel); end
    spi_gap();
    do_read(24'h000300, 1);
    checks++; if (rd_buf[0] !== 8'h96) begin failures++; $display("[TB] FAIL partial_data: got %h expected 96", rd_buf[0]); end
  endtask

  task automatic test_reset_mid_read();
    logic [2:0] bits;
    do_wren();
    spi_begin();
    spi_header(8'h03, 24'h000123);
    spi_bit(1'b0, bits[2]);
    spi_bit(1'b0, bits[1]);
    spi_bit(1'b0, bits[0]);
    checks++; if (bits !== 3'b101) begin failures++; $display("[TB] FAIL midread_bits: got %b expected 101", bits); end
    reset = 1'b0;
    #1;
    checks++; if (miso !== 1'b1) begin failures++; $display("[TB] FAIL midreset_miso: got %b expected released(1)", miso); end
    checks++; if (wel !== 1'b0) begin failures++; $display("[TB] FAIL midreset_wel: got %b expected 0", wel); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
    #19;
    reset = 1'b1;
    #50;
    i_spi_cs = 1'b1;
    spi_gap();
    do_read(24'h000123, 1);
    checks++; if (rd_buf[0] !== 8'hA5) begin failures++; $display("[TB] FAIL after_reset_read: got %h expected a5", rd_buf[0]); end
  endtask

  initial begin
    clk        = 1'b0;
    reset      = 1'b1;
    i_spi_clk  = 1'b0;
    i_spi_mosi = 1'b0;
    i_spi_cs   = 1'b1;
    checks     = 0;
    failures   = 0;
    err_pulses = 0;
    test_reset();
    test_write_enable();
    test_program();
    test_program_no_wel();
    test_bad_opcode();
    test_read_while_busy();
    test_status_poll();
    test_wrap();
    test_partial_program();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
SPI Mode 0 slave that emulates the serial flash/EEPROM seen by our 6809 SPI flash controller. It answers READ (0x03), WRITE ENABLE (0x06), PAGE PROGRAM (0x02) and READ STATUS (0x05) from an internal byte array, including a write-in-progress busy window. It is used as an FPGA-hosted flash stand-in and as the bench responder for controller regression.

Parameters:
ADDR_BITS, 12, array depth is 2^ADDR_BITS bytes; SPI address bits above ADDR_BITS-1 are ignored.
SYNC_STAGES, 2, synchronizer depth on i_SPI_CLK, i_SPI_MOSI and i_SPI_CS.
WRITE_BUSY_CYCLES, 100, clk cycles that WIP stays set after a program completes.

Ports:
clk  input  1  system clock; must be at least 8x the SPI clock.
reset  input  1  asynchronous, active-low reset.
i_SPI_CLK  input  1  SPI clock from master; idles low (Mode 0).
i_SPI_MOSI  input  1  master-out data, sampled on SPI clock rising edge.
i_SPI_CS  input  1  chip select, active low.
o_SPI_MISO  output  1  slave-out data; 1'bz whenever not driving.
o_busy  output  1  WIP flag (program window active).
o_wel  output  1  write-enable latch.
o_cmd_error  output  1  one-clk pulse on an unsupported opcode or a rejected command.

Behaviour:
- Reset (async, reset=0): state IDLE, o_SPI_MISO=z, o_busy=0, o_wel=0, o_cmd_error=0, bit/byte counters=0, busy counter=0. Array contents are not reset. Reset asserted mid-transaction aborts it and writes no partial data.
- All three SPI inputs pass through SYNC_STAGES flops. Edges are detected on the synchronized SCK. Rising edge shifts MOSI into the 8-bit shift register, MSB first. Falling edge advances MISO to the next bit.
- CS high, or a synchronized CS rising edge: state returns to IDLE, MISO=z, bit counter=0. CS falling edge enters CMD.
- States: IDLE, CMD, ADDR, READ_DATA, PROG_DATA, STATUS, IGNORE.
- CMD: after 8 rising edges, decode the opcode.
  - 0x03 -> ADDR. If o_busy=1 -> IGNORE and pulse o_cmd_error.
  - 0x02 -> ADDR. If o_wel=0 or o_busy=1 -> IGNORE and pulse o_cmd_error.
  - 0x06 -> IGNORE. WEL is set at CS rise only if exactly 8 bits were clocked and o_busy=0.
  - 0x05 -> STATUS.
  - Any other opcode -> IGNORE and pulse o_cmd_error.
- ADDR: shift 24 bits; the address register keeps bits [ADDR_BITS-1:0].
- READ_DATA: the byte at the address is fetched when the 32nd rising edge is detected. MISO drives its MSB within 2 clk after that edge (before the next SCK falling edge). Each further falling edge shifts out the next bit. After 8 bits the address increments, wrapping from 2^ADDR_BITS-1 to 0, and the next byte is fetched. This continues until CS rises.
- PROG_DATA: each complete 8-bit byte is written to the array at the address. The address then increments within its 256-byte page (low 8 bits wrap, upper bits held). A trailing partial byte at CS rise is discarded.
- On CS rise after PROG_DATA with at least 1 byte written: o_wel=0, o_busy=1, busy counter=WRITE_BUSY_CYCLES. The counter decrements once per clk, and o_busy clears on the clk where it reaches 0. With 0 bytes written: o_wel=0 and no busy window.
- STATUS: shifts out {6'b0, o_wel, o_busy} repeatedly until CS rises. The value is re-captured at each byte boundary so the master can poll WIP.
- IGNORE: MISO=z; only CS rise exits.
- MISO is driven only in READ_DATA or STATUS with CS low; otherwise z.
- Simultaneous events: a CS rise in the same clk as an SCK edge takes priority and the edge is dropped. A busy-counter expiry in the same clk as a status capture is reported as WIP=0.

Test Plan:
- After reset: o_SPI_MISO=z, o_busy=0, o_wel=0. Read 0x03/000000 returns the preloaded array value on MISO bits 32..39.
- Send 0x06 (CS high) -> o_wel=1. Send 0x02 000123 A5 (CS high) -> o_wel=0, o_busy=1 for exactly 100 clk, then 0. A subsequent read of 000123 returns 0xA5.
- Send 0x02 without a prior 0x06 -> o_cmd_error pulses. Array at the target address is unchanged and o_busy stays 0.
- During the busy window: 0x05 returns 0x01 and continues polling until WIP clears, then returns 0x00. A 0x03 issued while busy gives MISO=z and o_cmd_error pulses.
- Sequential read starting at 000FFF for 2 bytes -> array[FFF] then array[000] (address wrap). Program 3 bytes starting at 0000FE -> bytes land at FE, FF and 00 of page 0x000.
- CS raised after 4 data bits of a program, and reset asserted mid-read -> no array write and no busy window; all outputs return to their reset values immediately.
